// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit holding the HI/LO registers.
// Optional MULDIV_DIVZERO_FAST_EN: early divide-by-zero exit plus div_by_zero flag.
module muldiv_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [4:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MULDIV_DIVZERO_FAST_EN
    ,
    output logic             div_by_zero
`endif
);

    localparam logic [4:0] OP_MULT  = 5'b10000;
    localparam logic [4:0] OP_MULTU = 5'b10001;
    localparam logic [4:0] OP_DIV   = 5'b10010;
    localparam logic [4:0] OP_DIVU  = 5'b10011;
    localparam logic [4:0] OP_MTHI  = 5'b10100;
    localparam logic [4:0] OP_MTLO  = 5'b10101;
    localparam int CW = $clog2(WIDTH + MUL_LAT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, dvs;
    logic               q_neg, r_neg, dz, op_div;

    logic               sgn_mul, sgn_div, is_mul, is_div;
    logic               can_issue, iss_mul, iss_div, iss_mthi, iss_mtlo;
    logic               fast_dz, wr_ok;
    logic [2*WIDTH-1:0] ma, mb;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     rem_sh;
    logic               ge;
    logic [WIDTH-1:0]   rem_nx, quo_nx, q_fin, r_fin, res_hi, res_lo;

    assign sgn_mul = (alucontrol == OP_MULT);
    assign sgn_div = (alucontrol == OP_DIV);
    assign is_mul  = sgn_mul | (alucontrol == OP_MULTU);
    assign is_div  = sgn_div | (alucontrol == OP_DIVU);

    // DONE is a writeback slot, so a new op may issue there
    assign can_issue = start & ~cancel &
                       ((state == S_IDLE) | (state == S_DONE));
    assign iss_mul  = can_issue & is_mul;
    assign iss_div  = can_issue & is_div;
    assign iss_mthi = can_issue & (alucontrol == OP_MTHI);
    assign iss_mtlo = can_issue & (alucontrol == OP_MTLO);

    assign busy  = (state == S_MUL) | (state == S_DIV);
    assign stall = busy | iss_mul | iss_div;
    assign done  = (state == S_DONE) & ~cancel;
    assign wr_ok = ~(op_div & dz);

`ifdef MULDIV_DIVZERO_FAST_EN
    assign fast_dz     = dz;
    assign div_by_zero = done & op_div & dz;
`else
    assign fast_dz = 1'b0;
`endif

    assign ma = {{WIDTH{sgn_mul & a[WIDTH-1]}}, a};
    assign mb = {{WIDTH{sgn_mul & b[WIDTH-1]}}, b};

    // -MIN wraps to MIN, which is the correct unsigned magnitude
    assign a_mag = (sgn_div & a[WIDTH-1]) ? -a : a;
    assign b_mag = (sgn_div & b[WIDTH-1]) ? -b : b;

    assign rem_sh = {rem, quo[WIDTH-1]};
    assign ge     = rem_sh >= {1'b0, dvs};
    assign rem_nx = ge ? (rem_sh[WIDTH-1:0] - dvs) : rem_sh[WIDTH-1:0];
    assign quo_nx = {quo[WIDTH-2:0], ge};

    assign q_fin  = q_neg ? -quo : quo;
    assign r_fin  = r_neg ? -rem : rem;
    assign res_hi = op_div ? r_fin : prod[2*WIDTH-1:WIDTH];
    assign res_lo = op_div ? q_fin : prod[WIDTH-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_DONE: begin
                state_n = S_IDLE;
                if (iss_mul)
                    state_n = (MUL_LAT > 1) ? S_MUL : S_DONE;
                else if (iss_div)
                    state_n = S_DIV;
            end
            S_MUL: if (cnt == '0) state_n = S_DONE;
            S_DIV: if (cnt == '0 || fast_dz) state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
        if (cancel) state_n = S_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt    <= '0;
            prod   <= '0;
            quo    <= '0;
            rem    <= '0;
            dvs    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            dz     <= 1'b0;
            op_div <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            if (iss_mul) begin
                prod   <= ma * mb;
                op_div <= 1'b0;
                cnt    <= CW'(MUL_LAT > 1 ? MUL_LAT - 2 : 0);
            end
            if (iss_div) begin
                quo    <= a_mag;
                dvs    <= b_mag;
                rem    <= '0;
                q_neg  <= sgn_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                r_neg  <= sgn_div & a[WIDTH-1];
                dz     <= (b == '0);
                op_div <= 1'b1;
                cnt    <= CW'(WIDTH - 1);
            end
            if (state == S_MUL && cnt != '0)
                cnt <= cnt - CW'(1);
            if (state == S_DIV) begin
                rem <= rem_nx;
                quo <= quo_nx;
                if (cnt != '0) cnt <= cnt - CW'(1);
            end
            if (done && wr_ok) begin
                hi <= res_hi;
                lo <= res_lo;
            end
            // a move issued in DONE is younger than the result being retired
            if (iss_mthi) hi <= a;
            if (iss_mtlo) lo <= a;
        end
    end

endmodule
